roi_luma_mask: RTL
==================

ROI_LUMA_MASK -- requirements
Module: roi_luma_mask

Interface
REQ-001 SHALL have parameters (name, default, meaning): PIX_W, 8, luma width; COORD_W, 10, tv_x/tv_y width; CNT_W, 20, frame counter width; DEL_X_DEF, 115, reset corner inset X; DEL_Y_DEF, 30, reset corner inset Y.
REQ-002 SHALL have ports (name direction width meaning): clk in 1 pixel clock; rst in 1 synchronous active-high reset; pix_valid in 1 pixel strobe; Y in PIX_W luma; tv_x in COORD_W column; tv_y in COORD_W row; frame_start in 1 first-pixel-of-frame strobe.
REQ-003 SHALL have config ports: x1, y1, x2, y2 in COORD_W window corners; del_x, del_y in COORD_W corner insets; Y_lo, Y_hi in PIX_W thresholds; mode in 2 compare mode; cfg_load in 1 config request.
REQ-004 SHALL have outputs: mask_valid out 1; mask out 1; mask_x, mask_y out COORD_W; frame_cnt out CNT_W masked pixels in last frame; cnt_valid out 1 one-cycle strobe; cfg_err out 1 sticky bad-config flag.
REQ-005 Clock and reset: one clock, clk; reset is synchronous and active-high, named rst.

Function
REQ-006 SHALL hold shadow config (x1..del_y, Y_lo, Y_hi, mode); cfg_load sets a pending flag; shadow copies live inputs on the cycle frame_start&pix_valid is seen with pending=1, then pending clears.
REQ-007 SHALL apply the new shadow to that frame_start pixel itself; config never changes mid-frame.
REQ-008 SHALL compute bounds in COORD_W+2 signed: ya=y1+del_y, yb=y2-del_y, xa=x1+del_x, xb=x2-del_x; negatives clamp to 0.
REQ-009 SHALL define region = (ya<=tv_y<yb) OR ((tv_y<ya OR tv_y>=yb) AND xa<tv_x<xb).
REQ-010 SHALL evaluate luma per mode: 0 Y<Y_lo; 1 Y>Y_hi; 2 Y_lo<=Y<=Y_hi; 3 mask forced 0 (bypass).
REQ-011 SHALL pipeline 2 stages: stage 1 registers region and luma bits with coords; stage 2 registers mask=region&luma; mask_valid = pix_valid delayed 2 cycles; mask_x/mask_y align with mask.
REQ-012 SHALL hold mask, mask_x, mask_y when mask_valid=0; gaps in pix_valid are bubbles, not stalls.
REQ-013 SHALL count mask=1 outputs in an accumulator saturating at 2^CNT_W-1.
REQ-014 At frame_start reaching stage 2 (flag piped with data): frame_cnt<=accumulator (excluding that pixel), cnt_valid pulses 1 cycle, accumulator restarts at that pixel's mask value.
REQ-015 SHALL suppress cnt_valid on the first frame_start after reset (no prior frame).
REQ-016 SHALL set cfg_err when a loaded shadow has ya>=yb or xa>=xb or (mode=2 and Y_lo>Y_hi); cleared only by rst or a later valid load; affected frame masks all 0.
REQ-017 frame_start without pix_valid SHALL be ignored.

Reset
REQ-018 rst SHALL clear: mask, mask_valid, mask_x, mask_y, frame_cnt, cnt_valid, cfg_err, accumulator, pending, pipeline valids to 0.
REQ-019 rst SHALL load shadow: x1=y1=0, x2=y2=2^COORD_W-1, del_x=DEL_X_DEF, del_y=DEL_Y_DEF, Y_lo=Y_hi=0, mode=3.
REQ-020 rst mid-frame SHALL drop in-flight pixels; outputs resume 2 cycles after first pix_valid post-reset.

Structure
REQ-021 Shared package SHALL hold mode encodings (MODE_BELOW, MODE_ABOVE, MODE_BAND, MODE_OFF) and defaults DEL_X_DEF/DEL_Y_DEF.
REQ-022 Bound computation and region test SHALL be sub-module roi_region (combinational, parameter COORD_W).

Verification
REQ-023 Reset then 4 pixels, no cfg_load -> mask=0 all; cnt_valid never pulses.
REQ-024 x1=y1=0, x2=639, y2=479, del 115/30, mode 0, Y_lo=100; Y=50 at (10,10) -> mask=0; (200,10) -> 1; (10,100) -> 1; Y=150 at (200,100) -> 0; mask 2 cycles after pix_valid.
REQ-025 cfg_load mid-frame changing mode 0->1 -> current frame uses mode 0; switches exactly at next frame_start pixel.
REQ-026 Frame with 37 masked pixels, then frame_start -> frame_cnt=37, cnt_valid 1 cycle; CNT_W=4, 20 masked -> frame_cnt=15.
REQ-027 Load y1=200,y2=220,del_y=30 -> cfg_err=1, masks 0; reload valid config -> cfg_err=0 at next frame_start.
REQ-028 rst asserted with 2 pixels in flight -> mask_valid=0 next cycle, frame_cnt=0, no stale output.

Source files
------------

// File: rtl/roi_luma_mask_pkg.sv
// rtl/roi_luma_mask_pkg.sv - shared mode encodings and default corner insets
// Purpose: common definitions for the ROI luma mask block.
// Contents: mode_e (compare modes), DEL_X_DEF / DEL_Y_DEF reset corner insets.
package roi_luma_mask_pkg;

  typedef enum logic [1:0] {
    MODE_BELOW = 2'd0,   // Y <  Y_lo
    MODE_ABOVE = 2'd1,   // Y >  Y_hi
    MODE_BAND  = 2'd2,   // Y_lo <= Y <= Y_hi
    MODE_OFF   = 2'd3    // mask forced to 0
  } mode_e;

  localparam int DEL_X_DEF = 115;
  localparam int DEL_Y_DEF = 30;

endpackage

// File: rtl/roi_luma_mask_if.sv
// rtl/roi_luma_mask_if.sv - pixel-in / mask-out stream bundle
// Purpose: groups the pixel stream and the aligned mask stream.
// Ports: pix_valid, Y, tv_x, tv_y, frame_start (producer -> block);
//        mask_valid, mask, mask_x, mask_y (block -> consumer).
// Modports: master = pixel source / mask sink, slave = the mask block.
interface roi_luma_mask_if #(
  parameter int PIX_W   = 8,
  parameter int COORD_W = 10
);

  logic               pix_valid;
  logic [PIX_W-1:0]   Y;
  logic [COORD_W-1:0] tv_x;
  logic [COORD_W-1:0] tv_y;
  logic               frame_start;

  logic               mask_valid;
  logic               mask;
  logic [COORD_W-1:0] mask_x;
  logic [COORD_W-1:0] mask_y;

  modport master (
    output pix_valid, Y, tv_x, tv_y, frame_start,
    input  mask_valid, mask, mask_x, mask_y
  );

  modport slave (
    input  pix_valid, Y, tv_x, tv_y, frame_start,
    output mask_valid, mask, mask_x, mask_y
  );

endinterface

// File: rtl/roi_region.sv
// rtl/roi_region.sv - window bounds and region membership (combinational)
// Purpose: derives inset bounds from the window corners and tests a pixel
//          coordinate against them.
// Ports: x1,y1,x2,y2 window corners; del_x,del_y corner insets;
//        tv_x,tv_y pixel coordinate; region = pixel inside the shape;
//        bad = bounds are empty (ya>=yb or xa>=xb).
module roi_region #(
  parameter int COORD_W = 10
) (
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  input  logic [COORD_W-1:0] x2,
  input  logic [COORD_W-1:0] y2,
  input  logic [COORD_W-1:0] del_x,
  input  logic [COORD_W-1:0] del_y,
  input  logic [COORD_W-1:0] tv_x,
  input  logic [COORD_W-1:0] tv_y,
  output logic               region,
  output logic               bad
);

  localparam int SW = COORD_W + 2;

  logic signed [SW-1:0] ya, yb, xa, xb, yb_raw, xb_raw, tx, ty;
  logic                 in_band;

  function automatic logic signed [SW-1:0] ext(input logic [COORD_W-1:0] v);
    return $signed({2'b00, v});
  endfunction

  always_comb begin
    // Two extra bits: one for the carry of corner+inset, one for the sign
    // of corner-inset so that an oversized inset can be clamped to 0.
    ya     = ext(y1) + ext(del_y);
    xa     = ext(x1) + ext(del_x);
    yb_raw = ext(y2) - ext(del_y);
    xb_raw = ext(x2) - ext(del_x);
    yb     = yb_raw[SW-1] ? '0 : yb_raw;
    xb     = xb_raw[SW-1] ? '0 : xb_raw;
    tx     = ext(tv_x);
    ty     = ext(tv_y);

    // Full-width band between ya and yb, plus a narrowed column above and
    // below it: the window with its four corners cut away.
    in_band = (ya <= ty) && (ty < yb);
    region  = in_band || (((ty < ya) || (ty >= yb)) && (xa < tx) && (tx < xb));
    bad     = (ya >= yb) || (xa >= xb);
  end

endmodule

// File: rtl/roi_luma_mask.sv
// rtl/roi_luma_mask.sv - region-of-interest luma mask with per-frame count
// Purpose: marks pixels inside a corner-cut window whose luma passes the
//          selected compare, two-stage pipelined, and counts marked pixels
//          per frame.
// Ports: clk, rst (sync active-high); pix (slave modport: pixel stream in,
//        mask stream out); x1..del_y, Y_lo, Y_hi, mode live config with
//        cfg_load request; frame_cnt/cnt_valid per-frame count report;
//        cfg_err sticky bad-config flag.
module roi_luma_mask
  import roi_luma_mask_pkg::*;
#(
  parameter int PIX_W     = 8,
  parameter int COORD_W   = 10,
  parameter int CNT_W     = 20,
  parameter int DEL_X_DEF = roi_luma_mask_pkg::DEL_X_DEF,
  parameter int DEL_Y_DEF = roi_luma_mask_pkg::DEL_Y_DEF
) (
  input  logic               clk,
  input  logic               rst,
  roi_luma_mask_if.slave     pix,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  input  logic [COORD_W-1:0] x2,
  input  logic [COORD_W-1:0] y2,
  input  logic [COORD_W-1:0] del_x,
  input  logic [COORD_W-1:0] del_y,
  input  logic [PIX_W-1:0]   Y_lo,
  input  logic [PIX_W-1:0]   Y_hi,
  input  logic [1:0]         mode,
  input  logic               cfg_load,
  output logic [CNT_W-1:0]   frame_cnt,
  output logic               cnt_valid,
  output logic               cfg_err
);

  // Shadow config, only replaced on a frame_start pixel
  logic [COORD_W-1:0] sh_x1, sh_y1, sh_x2, sh_y2, sh_del_x, sh_del_y;
  logic [PIX_W-1:0]   sh_ylo, sh_yhi;
  logic [1:0]         sh_mode;
  logic               pending;

  // Config in effect for the pixel currently at the input
  logic [COORD_W-1:0] e_x1, e_y1, e_x2, e_y2, e_del_x, e_del_y;
  logic [PIX_W-1:0]   e_ylo, e_yhi;
  mode_e              e_mode;
  logic               take, region, bounds_bad, e_bad, luma_hit;

  // Pipeline
  logic               s1_valid, s1_region, s1_luma, s1_fs, s2_hit;
  logic [COORD_W-1:0] s1_x, s1_y;
  logic [CNT_W-1:0]   acc;
  logic               seen_frame;

  // The frame_start pixel that consumes a pending load already uses the new
  // values, so the live inputs are forwarded around the shadow on that cycle.
  assign take    = pix.pix_valid & pix.frame_start & pending;
  assign e_x1    = take ? x1    : sh_x1;
  assign e_y1    = take ? y1    : sh_y1;
  assign e_x2    = take ? x2    : sh_x2;
  assign e_y2    = take ? y2    : sh_y2;
  assign e_del_x = take ? del_x : sh_del_x;
  assign e_del_y = take ? del_y : sh_del_y;
  assign e_ylo   = take ? Y_lo  : sh_ylo;
  assign e_yhi   = take ? Y_hi  : sh_yhi;
  assign e_mode  = mode_e'(take ? mode : sh_mode);

  roi_region #(.COORD_W(COORD_W)) u_region (
    .x1(e_x1), .y1(e_y1), .x2(e_x2), .y2(e_y2),
    .del_x(e_del_x), .del_y(e_del_y),
    .tv_x(pix.tv_x), .tv_y(pix.tv_y),
    .region(region), .bad(bounds_bad)
  );

  // Badness is a pure function of the effective config, so it holds for the
  // whole frame without a separate stored copy.
  assign e_bad = bounds_bad | ((e_mode == MODE_BAND) && (e_ylo > e_yhi));

  always_comb begin
    luma_hit = 1'b0;
    case (e_mode)
      MODE_BELOW: luma_hit = (pix.Y < e_ylo);
      MODE_ABOVE: luma_hit = (pix.Y > e_yhi);
      MODE_BAND:  luma_hit = (pix.Y >= e_ylo) && (pix.Y <= e_yhi);
      default:    luma_hit = 1'b0;
    endcase
  end

  assign s2_hit = s1_region & s1_luma;

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_x1      <= '0;
      sh_y1      <= '0;
      sh_x2      <= '1;
      sh_y2      <= '1;
      sh_del_x   <= COORD_W'(DEL_X_DEF);
      sh_del_y   <= COORD_W'(DEL_Y_DEF);
      sh_ylo     <= '0;
      sh_yhi     <= '0;
      sh_mode    <= MODE_OFF;
      pending    <= 1'b0;
      cfg_err    <= 1'b0;
      s1_valid   <= 1'b0;
      s1_region  <= 1'b0;
      s1_luma    <= 1'b0;
      s1_fs      <= 1'b0;
      s1_x       <= '0;
      s1_y       <= '0;
      pix.mask_valid <= 1'b0;
      pix.mask       <= 1'b0;
      pix.mask_x     <= '0;
      pix.mask_y     <= '0;
      acc        <= '0;
      frame_cnt  <= '0;
      cnt_valid  <= 1'b0;
      seen_frame <= 1'b0;
    end else begin
      if (take) begin
        sh_x1    <= x1;
        sh_y1    <= y1;
        sh_x2    <= x2;
        sh_y2    <= y2;
        sh_del_x <= del_x;
        sh_del_y <= del_y;
        sh_ylo   <= Y_lo;
        sh_yhi   <= Y_hi;
        sh_mode  <= mode;
        pending  <= 1'b0;
        cfg_err  <= e_bad;
      end
      // A request arriving on the consuming cycle stays pending for the next frame
      if (cfg_load) pending <= 1'b1;

      // Stage 1
      s1_valid <= pix.pix_valid;
      if (pix.pix_valid) begin
        s1_region <= region & ~e_bad;
        s1_luma   <= luma_hit;
        s1_fs     <= pix.frame_start;
        s1_x      <= pix.tv_x;
        s1_y      <= pix.tv_y;
      end

      // Stage 2 and frame accounting
      pix.mask_valid <= s1_valid;
      cnt_valid      <= 1'b0;
      if (s1_valid) begin
        pix.mask   <= s2_hit;
        pix.mask_x <= s1_x;
        pix.mask_y <= s1_y;
        if (s1_fs) begin
          if (seen_frame) begin
            frame_cnt <= acc;
            cnt_valid <= 1'b1;
          end
          seen_frame <= 1'b1;
          acc        <= CNT_W'(s2_hit);
        end else if (s2_hit && (acc != '1)) begin
          acc <= acc + CNT_W'(1);
        end
      end
    end
  end

endmodule
